mdu: RTL and testbench
======================

Name: mdu

Overview:
Parametrised multiply/divide unit for the pipelined CPU. It sits beside the combinational ALU in the EX stage and executes MULT/MULTU/DIV/DIVU iteratively. Results go into architectural HI/LO registers, and the block also serves MTHI/MTLO/MFHI/MFLO. A start/busy/done handshake lets the hazard unit stall later HI/LO consumers.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and >= 4.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request strobe; accepted only when busy=0
op  input  3  operation select (MDU_* codes)
A  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
B  input  WIDTH  multiplier / divisor
cancel  input  1  synchronous abort of the in-flight op (pipeline flush)
busy  output  1  high while an iterative op is in flight
done  output  1  one-cycle pulse when HI/LO take a new iterative result
hi  output  WIDTH  HI register (MFHI source)
lo  output  WIDTH  LO register (MFLO source)

Behaviour:
- Reset: async assert forces state=IDLE, busy=0, done=0, hi=0, lo=0, and clears all internal accumulators. Reset mid-operation discards the op.
- Op codes: MDU_NOP=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6. Codes 7 and NOP behave as no-ops with no state change.
- Acceptance: start=1 and busy=0 at a rising edge. start while busy=1 is ignored, with no queueing.
- MTHI/MTLO: single cycle. hi (or lo) takes A at the accepting edge. busy stays 0 and done is not pulsed.
- Iterative ops (MULT/MULTU/DIV/DIVU):
  - At the accepting edge, latch operand magnitudes and the sign flags, and go to the RUN state with busy=1.
  - Signed variants take absolute values. Unsigned variants treat operands as raw.
- State machine IDLE -> RUN -> FIX -> IDLE.
  - RUN lasts exactly WIDTH cycles, with a counter from WIDTH-1 down to 0.
  - Multiply is radix-2 shift-add into a 2*WIDTH product.
  - Divide is restoring: one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
  - FIX lasts one cycle and applies sign correction.
  - At the edge leaving FIX, hi/lo are written, busy falls, and done=1 for the following cycle.
- Latency: accept edge at cycle 0. hi/lo are valid, busy=0 and done=1 in cycle WIDTH+2. busy is high for WIDTH+1 cycles total.
- Multiply result: {hi,lo} = full 2*WIDTH product. For MULT, negate the product if the sign flags differ.
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero.
  - Remainder sign follows the dividend.
  - Signed overflow (min_int / -1) gives lo = min_int and hi = 0. This falls out of the magnitude datapath and needs no special case.
- Divide by zero (B=0, signed or unsigned): still takes the full latency. Result is lo = all ones and hi = A, the raw dividend. No exception is raised.
- cancel: in RUN or FIX, it returns the block to IDLE at the next edge with busy=0 and no done. hi/lo keep their prior values.
  - cancel in IDLE has no effect.
  - cancel and start in the same cycle: cancel wins, so the op is not accepted and MTHI/MTLO are not written.
- hi/lo are registered outputs and change only at the points defined above. Reading during busy returns the old values, and the hazard unit is responsible for stalling.
- done and a new start in the same cycle: the new op is accepted, because busy is already 0.

Decomposition:
- MDU_* op codes go in the shared ctrl_encode_def.v define file, alongside the ALU_* codes. State encodings stay local.
- One sub-module is natural: mdu_div_core, the WIDTH-cycle restoring divider on magnitudes with a start/count interface.
- The multiplier shift-add loop stays inline in mdu, as does the sign FIX logic.

Test Plan:
- MULT, A=-3 (0xFFFFFFFD), B=7 -> after 34 cycles: hi=0xFFFFFFFF, lo=0xFFFFFFEB, one done pulse, busy high for 33 cycles.
- MULTU, A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE. A second start while busy is ignored, so hi/lo are unchanged by it.
- DIV, A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU, A=7, B=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- MTHI A=0x12345678, then MTLO A=0xCAFEBABE on the next cycle -> hi/lo update on consecutive edges, busy never asserts, done never pulses.
- DIV 100/7 with cancel in RUN cycle 10 -> busy low next cycle, no done, hi/lo retain the prior values. A follow-up DIVU 100/7 -> lo=14, hi=2.
- MULT in progress, assert rst asynchronously mid-cycle -> hi=lo=0 immediately and busy=0. After release, MULT 0x80000000 * -1 -> hi=0, lo=0x80000000.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes and latched-operation flags for the multiply/divide unit.
// Op codes are plain 3-bit constants so that undefined code 7 stays legal on the op port.
package mdu_pkg;

  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef struct packed {
    logic is_div;
    logic neg_res;  // negate product or quotient in FIX
    logic neg_rem;  // negate remainder in FIX (dividend was negative)
    logic div0;
  } mdu_flags_t;

  function automatic logic op_is_iter(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring divider on unsigned magnitudes: load latches operands, each step
// retires one quotient bit, WIDTH steps produce quotient and remainder.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH:0]   diff;
  logic             fits;

  // quo_q doubles as the dividend shift register: its MSB feeds the partial
  // remainder while quotient bits enter at the LSB.
  always_comb begin
    part_rem = {rem_q, quo_q[WIDTH-1]};
    diff     = part_rem - {1'b0, dvsr_q};
    fits     = ~diff[WIDTH];
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    if (load) begin
      quo_d  = dividend;
      rem_d  = '0;
      dvsr_d = divisor;
    end else if (step) begin
      quo_d = {quo_q[WIDTH-2:0], fits};
      rem_d = fits ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// IDLE -> RUN (WIDTH cycles) -> FIX (sign correction) -> IDLE with a done pulse.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  mdu_flags_t         flags_q, flags_d;

  logic               accept;
  logic               sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   mcand_sel;
  logic [WIDTH:0]     mul_sum;
  logic               div_load;
  logic               div_step;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quotient (quo),
    .remainder(rem)
  );

  // Operand magnitudes; min_int maps onto itself, which is exactly its magnitude unsigned.
  always_comb begin
    accept    = start && !cancel && (state_q == S_IDLE);
    sgn       = op_is_signed(op);
    a_mag     = (sgn && A[WIDTH-1]) ? -A : A;
    b_mag     = (sgn && B[WIDTH-1]) ? -B : B;
    mcand_sel = acc_q[0] ? mcand_q : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_sel};
    prod_fixed = flags_q.neg_res ? -acc_q : acc_q;
    quo_fixed  = flags_q.neg_res ? -quo : quo;
    rem_fixed  = flags_q.neg_rem ? -rem : rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    a_raw_d  = a_raw_q;
    flags_d  = flags_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == MDU_MTHI) begin
            hi_d = A;
          end else if (op == MDU_MTLO) begin
            lo_d = A;
          end else if (op_is_iter(op)) begin
            state_d         = S_RUN;
            busy_d          = 1'b1;
            cnt_d           = CW'(WIDTH - 1);
            mcand_d         = a_mag;
            acc_d           = {{WIDTH{1'b0}}, b_mag};
            a_raw_d         = A;
            flags_d.is_div  = op_is_div(op);
            flags_d.neg_res = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
            flags_d.neg_rem = sgn && A[WIDTH-1];
            flags_d.div0    = (B == '0);
            div_load        = op_is_div(op);
          end
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          // Shift-add: multiplier bits drain out of the low half as the product fills in.
          if (flags_q.is_div) div_step = 1'b1;
          else                acc_d    = {mul_sum, acc_q[WIDTH-1:1]};
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!cancel) begin
          done_d = 1'b1;
          if (!flags_q.is_div) begin
            {hi_d, lo_d} = prod_fixed;
          end else if (flags_q.div0) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fixed;
            lo_d = quo_fixed;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      a_raw_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      a_raw_q <= a_raw_d;
      flags_q <= flags_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written corner
// sequences (cancel, async reset, busy-ignore, MTHI/MTLO) and random ops vs a model.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          intr;
  } vec_t;

  vec_t vecs[10];

  mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Reference: architectural result computed directly from the arithmetic rules.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint sp;
    logic [63:0] p;
    int sa, sb;
    h = exp_hi;
    l = exp_lo;
    sa = a;
    sb = b;
    case (o)
      MDU_MULT: begin
        sp = longint'(sa) * longint'(sb);
        p = sp;
        h = p[63:32];
        l = p[31:0];
      end
      MDU_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      MDU_DIV: begin
        if (b == 0) begin h = a; l = '1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = '0; l = a; end
        else begin l = sa / sb; h = sa % sb; end
      end
      MDU_DIVU: begin
        if (b == 0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
      MDU_MTHI: h = a;
      MDU_MTLO: l = a;
      default: ;
    endcase
  endfunction

  // Issue an op and follow it until done (bounded). Optionally cancel or try
  // an intruding MTHI while busy. Returns busy-cycle count and done cycle index.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, input int intr_at,
                        output int busy_cnt, output int done_cyc);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0;
    done_cyc = 0;
    for (int k = 1; k <= 60; k++) begin
      if (busy) busy_cnt++;
      if (done) done_cyc = k;
      if (k == 2) begin
        check("hold_hi", {32'b0, hi}, {32'b0, exp_hi});
        check("hold_lo", {32'b0, lo}, {32'b0, exp_lo});
      end
      if (done_cyc != 0) break;
      if (k == cancel_at) cancel = 1'b1;
      if (k == intr_at) begin start = 1'b1; op = MDU_MTHI; A = 32'hDEADBEEF; end
      @(posedge clk); #1;
      cancel = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic single(input logic [2:0] o, input logic [31:0] a, input logic c);
    start = 1'b1; op = o; A = a; cancel = c;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int bc, dc;
    logic [31:0] ra, rb, mh, ml;
    logic [2:0] ro;

    vecs[0] = '{MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0};
    vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0};
    vecs[3] = '{MDU_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 0};
    vecs[4] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0};
    vecs[5] = '{MDU_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 0};
    vecs[6] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0};
    vecs[7] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0};
    vecs[8] = '{MDU_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 0};
    vecs[9] = '{MDU_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0};

    // Reset state, both while held and after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", {32'b0, hi}, 64'h0);
    check("rst_lo", {32'b0, lo}, 64'h0);
    check("rst_busy", {63'b0, busy}, 64'h0);
    check("rst_done", {63'b0, done}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", {63'b0, busy}, 64'h0);

    // Table vectors, issued back-to-back: each new start lands in the prior done cycle.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].intr, bc, dc);
      exp_hi = vecs[i].hi;
      exp_lo = vecs[i].lo;
      $display("txn vec%0d op=%0d a=%h b=%h hi=%h lo=%h busy_cycles=%0d done_cycle=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, bc, dc);
      check("vec_busy_cycles", 64'(bc), 64'd33);
      check("vec_done_cycle", 64'(dc), 64'd34);
      check("vec_hi", {32'b0, hi}, {32'b0, exp_hi});
      check("vec_lo", {32'b0, lo}, {32'b0, exp_lo});
    end
    @(posedge clk); #1;
    check("done_one_cycle", {63'b0, done}, 64'h0);

    // Async reset in the middle of a MULT clears hi/lo before the next edge.
    start = 1'b1; op = MDU_MULT; A = 32'hFFFFFFFD; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    $display("txn async_reset hi=%h lo=%h busy=%b", hi, lo, busy);
    check("arst_hi", {32'b0, hi}, 64'h0);
    check("arst_lo", {32'b0, lo}, 64'h0);
    check("arst_busy", {63'b0, busy}, 64'h0);
    #2 rst = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    @(posedge clk); #1;
    check("arst_stays_idle", {63'b0, busy}, 64'h0);
    run_op(MDU_MULT, 32'h80000000, 32'hFFFFFFFF, 0, 0, bc, dc);
    exp_hi = 32'h0;
    exp_lo = 32'h80000000;
    $display("txn mult_after_reset hi=%h lo=%h", hi, lo);
    check("mr_done_cycle", 64'(dc), 64'd34);
    check("mr_hi", {32'b0, hi}, {32'b0, exp_hi});
    check("mr_lo", {32'b0, lo}, {32'b0, exp_lo});
    @(posedge clk); #1;

    // MTHI then MTLO on consecutive edges.
    single(MDU_MTHI, 32'h12345678, 1'b0);
    $display("txn mthi hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    check("mthi_hi", {32'b0, hi}, 64'h12345678);
    check("mthi_lo", {32'b0, lo}, {32'b0, exp_lo});
    check("mthi_busy", {63'b0, busy}, 64'h0);
    single(MDU_MTLO, 32'hCAFEBABE, 1'b0);
    $display("txn mtlo hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    check("mtlo_lo", {32'b0, lo}, 64'hCAFEBABE);
    check("mtlo_hi", {32'b0, hi}, 64'h12345678);
    check("mtlo_busy", {63'b0, busy}, 64'h0);
    check("mtlo_done", {63'b0, done}, 64'h0);
    exp_hi = 32'h12345678;
    exp_lo = 32'hCAFEBABE;

    // cancel together with start in IDLE wins over the start.
    single(MDU_MTLO, 32'h0, 1'b1);
    check("cs_mtlo_lo", {32'b0, lo}, {32'b0, exp_lo});
    single(MDU_DIV, 32'd100, 1'b1);
    $display("txn cancel_with_start busy=%b lo=%h", busy, lo);
    check("cs_div_busy", {63'b0, busy}, 64'h0);

    // DIV 100/7 cancelled in RUN cycle 10, then a clean DIVU 100/7.
    B = 32'd7;
    run_op(MDU_DIV, 32'd100, 32'd7, 10, 0, bc, dc);
    $display("txn cancelled_div hi=%h lo=%h busy_cycles=%0d done_cycle=%0d", hi, lo, bc, dc);
    check("cancel_busy_cycles", 64'(bc), 64'd10);
    check("cancel_no_done", 64'(dc), 64'd0);
    check("cancel_hi", {32'b0, hi}, {32'b0, exp_hi});
    check("cancel_lo", {32'b0, lo}, {32'b0, exp_lo});
    run_op(MDU_DIVU, 32'd100, 32'd7, 0, 0, bc, dc);
    exp_hi = 32'd2;
    exp_lo = 32'd14;
    $display("txn divu_after_cancel hi=%h lo=%h", hi, lo);
    check("redo_done_cycle", 64'(dc), 64'd34);
    check("redo_hi", {32'b0, hi}, {32'b0, exp_hi});
    check("redo_lo", {32'b0, lo}, {32'b0, exp_lo});

    // Random ops against the reference model.
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      model(ro, ra, rb, mh, ml);
      if (op_is_iter(ro)) begin
        run_op(ro, ra, rb, 0, 0, bc, dc);
        check("rnd_done_cycle", 64'(dc), 64'd34);
      end else begin
        B = rb;
        single(ro, ra, 1'b0);
        check("rnd_single_busy", {63'b0, busy}, 64'h0);
        check("rnd_single_done", {63'b0, done}, 64'h0);
      end
      exp_hi = mh;
      exp_lo = ml;
      $display("txn rnd%0d op=%0d a=%h b=%h hi=%h lo=%h", i, ro, ra, rb, hi, lo);
      check("rnd_hi", {32'b0, hi}, {32'b0, exp_hi});
      check("rnd_lo", {32'b0, lo}, {32'b0, exp_lo});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
